// File: rtl/seg7_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_scan_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StDrive = 2'd2
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Valid/ready handoff of a packed hex value from a producer to the scan controller.
interface seg7_scan_controller_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                value_ready;

  modport master (output value, output value_valid, input value_ready);
  modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/decoderDisplay7Segment.sv
// Hex nibble to 7-segment decoder, active-high segments {dp,g,f,e,d,c,b,a}, dp always off.
module decoderDisplay7Segment (
  output logic [7:0] o,
  input  logic [3:0] i
);
  always_comb begin
    o = 8'h00;
    case (i)
      4'h0: o = 8'h3F;
      4'h1: o = 8'h06;
      4'h2: o = 8'h5B;
      4'h3: o = 8'h4F;
      4'h4: o = 8'h66;
      4'h5: o = 8'h6D;
      4'h6: o = 8'h7D;
      4'h7: o = 8'h07;
      4'h8: o = 8'h7F;
      4'h9: o = 8'h6F;
      4'hA: o = 8'h77;
      4'hB: o = 8'h7C;
      4'hC: o = 8'h39;
      4'hD: o = 8'h5E;
      4'hE: o = 8'h79;
      4'hF: o = 8'h71;
      default: o = 8'h00;
    endcase
  end
endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed hex display scanner with anti-ghost blanking and a frame-aligned double buffer.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  seg7_scan_controller_if.slave s_value,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_frame_done
);

  localparam int unsigned IDX_W = width_of(DIGITS);
  localparam int unsigned CNT_W = width_of(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                w_boundary;

  logic [4*DIGITS-1:0] r_active, r_pending;
  logic                r_pending_full;
  logic                w_accept, w_promote;

  logic [3:0]          w_nibble;
  logic [7:0]          w_dec;
  logic [7:0]          w_seg_nxt, r_seg;
  logic [DIGITS-1:0]   w_sel_nxt, r_digit_sel;
  logic                r_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = StBlank;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
      StBlank: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == BLANK_LAST) w_state_nxt = StDrive;
      end
      StDrive: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StBlank;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt  = '0;
            w_boundary = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // Disable overrides everything; the scan always restarts from digit 0.
    if (!i_enable) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_boundary  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Pending only reaches the display between frames (or while idle), so a frame never tears.
  assign w_accept  = s_value.value_valid && !r_pending_full;
  assign w_promote = r_pending_full && (w_boundary || (r_state == StIdle));
  assign s_value.value_ready = !r_pending_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pending      <= s_value.value;
        r_pending_full <= 1'b1;
      end else if (w_promote) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
      end
    end
  end

  // Entering or staying in DRIVE never changes the index, so r_idx selects the next digit.
  assign w_nibble = r_active[{r_idx, 2'b00} +: 4];

  decoderDisplay7Segment u_decoder (
    .o (w_dec),
    .i (w_nibble)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_lz_blank;

  always_comb begin
    w_lz_blank = '0;
    w_lz_blank[DIGITS-1] = (r_active[4*(DIGITS-1) +: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 1; k--) begin
      w_lz_blank[k] = w_lz_blank[k+1] && (r_active[4*k +: 4] == 4'h0);
    end
  end
`endif

  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_sel_nxt = '0;
    if (w_state_nxt == StDrive) begin
      w_sel_nxt = DIGITS'(1) << r_idx;
      w_seg_nxt = w_dec;
`ifdef LEADING_ZERO_BLANK_EN
      if (w_lz_blank[r_idx]) w_seg_nxt = SEG_OFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_digit_sel  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_digit_sel  <= w_sel_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign o_seg        = r_seg;
  assign o_digit_sel  = r_digit_sel;
  assign o_frame_done = r_frame_done;

endmodule
